muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, serving MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Runs a radix-2 iterative shift-add or restoring-division engine under an FSM and raises busy so the core stalls dependent MFHI/MFLO.
- Sits beside the single-cycle ALU, which keeps handling all other opcodes.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- op  in  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  synchronous cancel of the in-flight operation.
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wr_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  qualifies done; high when a div/divu had b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any state): FSM=IDLE; hi, lo, busy, done, div_by_zero, iteration counter and internal accumulators all 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start (edge 0):
  - latch op, a, b;
  - for signed ops, convert operands to magnitudes and record result signs;
  - counter=0; go to CALC. busy=1 from edge 0.
- CALC: one partial-product or quotient bit per cycle for exactly WIDTH cycles; counter saturates at WIDTH-1, then go to FIX.
- FIX, one cycle:
  - apply sign correction;
  - write hi/lo at the FIX edge (edge WIDTH+1);
  - go to DONE.
- DONE, one cycle: done=1, busy=0, div_by_zero valid. Next state is IDLE, or CALC if start is high.
- Latency: start at edge 0 -> results visible and done high in the cycle after edge WIDTH+1, i.e. 34 cycles for WIDTH=32. Latency is fixed regardless of operand values.
- Multiply:
  - {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
- Divide:
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- Divide by zero (b==0, div or divu):
  - same latency;
  - lo = all ones, hi = a as latched;
  - div_by_zero=1 during the done cycle, otherwise 0.
- Operands are latched at start; changes to a/b/op during CALC have no effect.
- start while busy: ignored, with no queuing.
- flush:
  - in CALC or FIX: return to IDLE next edge; hi/lo unchanged; no done pulse.
  - in IDLE/DONE: no effect, except that it suppresses a coincident start.
- wr_hi/wr_lo:
  - in IDLE or DONE: the register takes wr_data at the next edge.
  - while busy: ignored.
  - with start in the same cycle: start wins and the write is dropped.
  - wr_hi and wr_lo together: both written.
- rst asserted mid-operation: immediate return to the reset state; no done pulse.

Test Plan:
- multu a=FFFFFFFF b=FFFFFFFF, start at edge 0 -> busy high for edges 0..33; done high only in cycle 34; hi=FFFFFFFE, lo=00000001; div_by_zero=0.
- mult a=FFFFFFFD (-3) b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB. Then div a=FFFFFFF9 (-7) b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
- divu a=00000064 b=0 -> lo=FFFFFFFF, hi=00000064, div_by_zero=1 with done. Then div a=80000000 b=FFFFFFFF -> lo=80000000, hi=00000000, div_by_zero=0.
- start held high and a/b toggled during CALC -> only one result, matching the operands latched at edge 0. Re-asserting start in the DONE cycle launches a back-to-back op with no idle gap.
- flush at CALC cycle 10 -> FSM IDLE next edge, hi/lo keep prior values, done never pulses. wr_hi=1 with wr_data=12345678 while busy -> hi unchanged.
- rst pulsed mid-CALC -> all outputs 0 immediately. In IDLE, wr_lo with wr_data=0000ABCD -> lo=0000ABCD next edge. start+wr_hi in the same cycle -> hi takes the op result, not wr_data.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// A radix-2 shift-add / restoring-divide engine runs for WIDTH cycles, then one sign-fix cycle.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              dbz_q, dbz_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  upper_q, upper_d;
  logic [WIDTH-1:0]  lower_q, lower_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic              sgn;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH-1:0]  div_diff;
  logic              div_ge;
  logic [2*WIDTH-1:0] prod;
  logic              take;

  assign sgn   = ~op[0];
  assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

  // Multiply: accumulate into the upper half, shift the multiplier out of the lower half.
  assign mul_sum = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: remainder in the upper half, dividend shifts out / quotient shifts in below.
  assign div_shift = {upper_q, lower_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

  assign prod = {upper_q, lower_q};
  assign take = start && !flush && (state_q == StIdle || state_q == StDone);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dbz_d    = dbz_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    upper_d  = upper_q;
    lower_d  = lower_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (take) begin
          state_d  = StCalc;
          cnt_d    = '0;
          is_div_d = op[1];
          qneg_d   = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = sgn && a[WIDTH-1];
          dbz_d    = op[1] && (b == '0);
          a_d      = a;
          upper_d  = '0;
          opnd_d   = op[1] ? mag_b : mag_a;
          lower_d  = op[1] ? mag_a : mag_b;
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            upper_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lower_d = {lower_q[WIDTH-2:0], div_ge};
          end else begin
            upper_d = mul_sum[WIDTH:1];
            lower_d = {mul_sum[0], lower_q[WIDTH-1:1]};
          end
          if (cnt_q == CntMax) state_d = StFix;
          else                 cnt_d   = cnt_q + CntW'(1);
        end
      end
      StFix: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          state_d = StDone;
          if (!is_div_q) begin
            {hi_d, lo_d} = qneg_q ? -prod : prod;
          end else if (dbz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            lo_d = qneg_q ? -lower_q : lower_q;
            hi_d = rneg_q ? -upper_q : upper_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dbz_q    <= 1'b0;
      a_q      <= '0;
      opnd_q   <= '0;
      upper_q  <= '0;
      lower_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dbz_q    <= dbz_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      upper_q  <= upper_d;
      lower_q  <= lower_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy        = (state_q == StCalc) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign div_by_zero = (state_q == StDone) && dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model with a latency countdown,
// per-cycle comparison against it, and literal checks from hand-computed vectors.
module tb_muldiv_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         wr_hi = 1'b0;
  logic         wr_lo = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Returns {div_by_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] model_op(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
    longint       sx, sy, sq, sr;
    logic [63:0]  ux, uy, up;
    ux = {32'h0, x};
    uy = {32'h0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin sq = sx * sy; up = sq; return {1'b0, up}; end
      2'b01: begin up = ux * uy; return {1'b0, up}; end
      default: begin
        if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          sq = sx / sy;
          sr = sx % sy;
          return {1'b0, sr[31:0], sq[31:0]};
        end
        up = ux / uy;
        uy = ux % uy;
        return {1'b0, uy[31:0], up[31:0]};
      end
    endcase
  endfunction

  // Model state: remaining edges until the result lands, architectural HI/LO.
  int           m_rem;
  logic [W-1:0] m_hi, m_lo;
  logic         m_done, m_dbz;
  logic [64:0]  m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dbz <= 1'b0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        if (flush) begin
          m_rem <= 0;
        end else if (m_rem == 1) begin
          m_rem  <= 0;
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
          m_dbz  <= m_res[64];
          m_done <= 1'b1;
        end else begin
          m_rem <= m_rem - 1;
        end
      end else if (start && !flush) begin
        m_res <= model_op(op, a, b);
        m_rem <= W + 1;
      end else begin
        if (wr_hi) m_hi <= wr_data;
        if (wr_lo) m_lo <= wr_data;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_busy", {31'h0, busy}, {31'h0, m_rem != 0});
    chk("cyc_done", {31'h0, done}, {31'h0, m_done});
    chk("cyc_dbz", {31'h0, div_by_zero}, {31'h0, m_done && m_dbz});
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Returns edges waited after the launch edge; bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 100) begin
      step(1);
      edges++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: timeout after %0d edges, done=%b", edges, done);
    end
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                     input logic ez);
    int e;
    launch(o, x, y);
    wait_done(e);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    chk({name, "_dbz"}, {31'h0, div_by_zero}, {31'h0, ez});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    int pulses;
    step(3);
    rst = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);

    // Full-scale unsigned product, with latency: done 33 edges after the launch edge.
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("lat_busy0", {31'h0, busy}, 32'h1);
    wait_done(e);
    chk("lat_edges", e, 32'd33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("multu_dbz", {31'h0, div_by_zero}, 32'h0);
    step(1);
    chk("done_one_cycle", {31'h0, done}, 32'h0);

    run("mult", 2'b00, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run("div_negd", 2'b10, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run("div_both", 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h3, 1'b0);
    run("divu_z", 2'b11, 32'h64, 32'h0, 32'h64, 32'hFFFF_FFFF, 1'b1);
    run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);

    // start held and operands toggled while busy: only the latched op completes.
    op = 2'b01; a = 32'h5; b = 32'h6; start = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) begin
      a = 32'h100 + i; b = 32'h200 - i; op = 2'(i);
      step(1);
    end
    start = 1'b0;
    wait_done(e);
    chk("held_hi", hi, 32'h0);
    chk("held_lo", lo, 32'h1E);
    // Back-to-back launch from the DONE cycle.
    launch(2'b11, 32'd100, 32'd7);
    chk("b2b_busy", {31'h0, busy}, 32'h1);
    wait_done(e);
    chk("b2b_edges", e, 32'd33);
    chk("b2b_hi", hi, 32'h2);
    chk("b2b_lo", lo, 32'hE);

    // MTHI while busy is ignored; flush cancels with no done pulse.
    launch(2'b01, 32'h3, 32'h3);
    step(9);
    wr_hi = 1'b1; wr_data = 32'h1234_5678;
    step(1);
    wr_hi = 1'b0; flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      step(1);
    end
    chk("flush_pulses", pulses, 32'd0);
    chk("flush_hi", hi, 32'h2);
    chk("flush_lo", lo, 32'hE);

    // Asynchronous reset mid-operation.
    launch(2'b00, 32'h1234, 32'h5678);
    step(5);
    rst = 1'b1;
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    step(2);
    rst = 1'b0;
    step(1);

    wr_lo = 1'b1; wr_data = 32'h0000_ABCD;
    step(1);
    wr_lo = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_ABCD);
    chk("mtlo_hi", hi, 32'h0);

    // start wins over a coincident MTHI.
    wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
    launch(2'b01, 32'h2, 32'h3);
    wr_hi = 1'b0;
    wait_done(e);
    chk("startwin_hi", hi, 32'h0);
    chk("startwin_lo", lo, 32'h6);
    step(1);

    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h55AA_55AA;
    step(1);
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mtboth_hi", hi, 32'h55AA_55AA);
    chk("mtboth_lo", lo, 32'h55AA_55AA);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
